stream_demux_fifo: RTL and testbench
====================================

Name: stream_demux_fifo

Overview:
- Buffered, data-carrying stream demultiplexer.
- Routes each input beat (valid-ready) to one of N_OUP output streams, selected per beat by an index.
- Each output has its own FIFO of DEPTH entries, so one stalled consumer does not block traffic to the others until that consumer's FIFO fills.
- Placed between a shared request source and independent per-target pipelines.
- There is no combinational path from any oup_ready_i to inp_ready_o.

Parameters:
- N_OUP, 2: number of output streams, >= 1.
- DATA_WIDTH, 32: payload width in bits, >= 1.
- DEPTH, 2: entries per output FIFO, >= 1. Need not be a power of two.
- SEL_WIDTH, (N_OUP > 1) ? $clog2(N_OUP) : 1: width of the selector. Derived; do not override.
- CNT_WIDTH, $clog2(DEPTH+1): width of each occupancy counter. Derived; do not override.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous clear of all FIFOs and of err_o.
- inp_valid_i  in  1  input beat valid.
- inp_ready_o  out  1  input beat accepted.
- inp_data_i  in  DATA_WIDTH  input payload.
- oup_sel_i  in  SEL_WIDTH  target output index. Qualified by inp_valid_i.
- oup_valid_o  out  N_OUP  per-output valid.
- oup_ready_i  in  N_OUP  per-output ready.
- oup_data_o  out  N_OUP x DATA_WIDTH  per-output payload, packed, output i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- usage_o  out  N_OUP x CNT_WIDTH  per-output occupancy, packed.
- err_o  out  1  sticky flag: a beat with out-of-range selector was dropped.

Behaviour:
- Reset (rst_ni low, asynchronous), all outputs and state forced:
  - oup_valid_o = 0, usage_o = 0, err_o = 0.
  - All read/write pointers = 0.
  - inp_ready_o = 0 while rst_ni is low.
  - oup_data_o is don't-care (storage is not reset).
  - Reset mid-transfer discards all buffered beats.
- Input handshake: a beat transfers on a rising edge with inp_valid_i && inp_ready_o.
  - Per protocol, once inp_valid_i is high, inp_valid_i, inp_data_i and oup_sel_i stay stable until the transfer.
- inp_ready_o (combinational from sel, registered counts and flush_i):
  - 0 if flush_i = 1.
  - 1 if oup_sel_i >= N_OUP.
  - Otherwise 1 if and only if usage[oup_sel_i] < DEPTH.
  - A pop in the same cycle does not free space for a push (no pass-through).
  - inp_ready_o does not depend on inp_valid_i.
- Out-of-range selector (possible only when N_OUP is not a power of two):
  - The beat is accepted and discarded.
  - err_o goes to 1 on the next edge and holds until flush_i or reset.
- Push: the payload is written at wptr[sel], wptr wraps DEPTH-1 -> 0, usage[sel] increments.
- Latency: a beat is visible at the output one cycle after acceptance. There is no fall-through.
- Output i:
  - oup_valid_o[i] = (usage[i] != 0).
  - oup_data_o[i] = mem[i][rptr[i]].
  - Pop on oup_valid_o[i] && oup_ready_i[i]: rptr wraps DEPTH-1 -> 0, usage decrements.
- Per-output ordering is strict FIFO. There is no ordering guarantee across outputs.
- Simultaneous push and pop on the same output: usage is unchanged and both pointers advance. Legal at any occupancy 1..DEPTH-1; at DEPTH the push is blocked by ready.
- Independent outputs pop in the same cycle without interaction.
- oup_valid_o[i] is held until the pop. Data is stable while valid and not ready.
- flush_i = 1: on the next edge all usage and pointers are 0 and err_o is 0. Pops presented during the flush cycle are void.
- Pushes during flush: none, since ready is 0.
- Counters never exceed DEPTH or underflow. An assertion checks this.
- Assertions:
  - Input stability while valid and not ready.
  - usage <= DEPTH.
  - N_OUP >= 1 and DEPTH >= 1.
- N_OUP = 1 degenerates to a single FIFO; oup_sel_i is ignored (always index 0).

Test Plan:
- Reset then idle: after rst_ni rises with N_OUP=4, DEPTH=2 -> oup_valid_o=0000, usage all 0, err_o=0, inp_ready_o=1 for any sel.
- Routing/latency: push 0xA5 with sel=2 at cycle t -> oup_valid_o=0100 and oup_data_o[2]=0xA5 at t+1. Pop at t+1 -> usage[2]=0 at t+2.
- Full/back-pressure:
  - Hold oup_ready_i[1]=0 and push 3 beats to sel=1, DEPTH=2 -> inp_ready_o=0 on the third.
  - Concurrent pushes to sel=0 still accepted.
  - Raise oup_ready_i[1] for one cycle -> the third beat is accepted one cycle later.
  - Output 1 order is 1st, 2nd, 3rd.
- Simultaneous push/pop at usage=1 on output 3 for 10 cycles -> usage stays 1. Data emerges in order with 1-cycle lag. Pointers wrap cleanly for DEPTH=3.
- Out-of-range sel: N_OUP=3, sel=3 with valid -> accepted, no oup_valid_o change, err_o=1 next cycle. flush_i pulse -> err_o=0 and all usage 0.
- Reset mid-operation: two outputs hold 2 beats each and rst_ni is asserted asynchronously mid-cycle -> all oup_valid_o drop immediately. After release, outputs are empty and new beats route normally.

Source files
------------

// File: rtl/stream_demux_fifo.sv
// Buffered stream demultiplexer: each accepted beat is routed by oup_sel_i into
// one of N_OUP independent FIFOs; out-of-range selectors are dropped and flagged.
module stream_demux_fifo #(
   parameter int unsigned N_OUP      = 2,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 2,
   parameter int unsigned SEL_WIDTH  = (N_OUP > 1) ? $clog2(N_OUP) : 1,
   parameter int unsigned CNT_WIDTH  = $clog2(DEPTH + 1)
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          flush_i,
   input  logic                          inp_valid_i,
   output logic                          inp_ready_o,
   input  logic [DATA_WIDTH-1:0]         inp_data_i,
   input  logic [SEL_WIDTH-1:0]          oup_sel_i,
   output logic [N_OUP-1:0]              oup_valid_o,
   input  logic [N_OUP-1:0]              oup_ready_i,
   output logic [N_OUP*DATA_WIDTH-1:0]   oup_data_o,
   output logic [N_OUP*CNT_WIDTH-1:0]    usage_o,
   output logic                          err_o
);

   localparam int unsigned PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(DEPTH - 1);
   localparam logic [CNT_WIDTH-1:0] DEPTH_C  = CNT_WIDTH'(DEPTH);
   localparam logic [SEL_WIDTH:0]   N_OUP_C  = (SEL_WIDTH + 1)'(N_OUP);
   localparam bit                   MULTI    = (N_OUP > 1);

   logic [DATA_WIDTH-1:0] mem [N_OUP][DEPTH];
   logic [PTR_WIDTH-1:0]  wptr [N_OUP];
   logic [PTR_WIDTH-1:0]  rptr [N_OUP];
   logic [CNT_WIDTH-1:0]  usage [N_OUP];
   logic [N_OUP-1:0]      push_vec;
   logic [N_OUP-1:0]      pop_vec;
   logic [SEL_WIDTH-1:0]  sel_idx;
   logic                  oor;
   logic                  err_q;

   function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   // ready looks only at registered occupancy, so no oup_ready_i -> inp_ready_o path
   always_comb begin
      oor     = MULTI && ({1'b0, oup_sel_i} >= N_OUP_C);
      sel_idx = '0;
      if (MULTI && !oor) sel_idx = oup_sel_i;
      inp_ready_o = 1'b0;
      if (rst_ni && !flush_i) inp_ready_o = oor || (usage[sel_idx] < DEPTH_C);
      push_vec = '0;
      if (inp_valid_i && inp_ready_o && !oor) push_vec[sel_idx] = 1'b1;
   end

   always_comb begin
      oup_valid_o = '0;
      oup_data_o  = '0;
      usage_o     = '0;
      pop_vec     = '0;
      for (int unsigned i = 0; i < N_OUP; i++) begin
         oup_valid_o[i]                             = (usage[i] != '0);
         pop_vec[i]                                 = oup_valid_o[i] && oup_ready_i[i];
         oup_data_o[i*DATA_WIDTH +: DATA_WIDTH]     = mem[i][rptr[i]];
         usage_o[i*CNT_WIDTH +: CNT_WIDTH]          = usage[i];
      end
   end

   assign err_o = err_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < N_OUP; i++) begin
            wptr[i]  <= '0;
            rptr[i]  <= '0;
            usage[i] <= '0;
         end
         err_q <= 1'b0;
      end else if (flush_i) begin
         // flush wins over any pop presented in the same cycle
         for (int unsigned i = 0; i < N_OUP; i++) begin
            wptr[i]  <= '0;
            rptr[i]  <= '0;
            usage[i] <= '0;
         end
         err_q <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < N_OUP; i++) begin
            if (push_vec[i]) wptr[i] <= ptr_inc(wptr[i]);
            if (pop_vec[i])  rptr[i] <= ptr_inc(rptr[i]);
            case ({push_vec[i], pop_vec[i]})
               2'b10:   usage[i] <= usage[i] + 1'b1;
               2'b01:   usage[i] <= usage[i] - 1'b1;
               default: usage[i] <= usage[i];
            endcase
         end
         if (inp_valid_i && inp_ready_o && oor) err_q <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      for (int unsigned i = 0; i < N_OUP; i++) begin
         if (push_vec[i]) mem[i][wptr[i]] <= inp_data_i;
      end
   end

   assert property (@(posedge clk_i) (N_OUP >= 1) && (DEPTH >= 1));

   assert property (@(posedge clk_i) disable iff (!rst_ni)
      (inp_valid_i && !inp_ready_o) |=>
      (inp_valid_i && $stable(inp_data_i) && $stable(oup_sel_i)));

   for (genvar g = 0; g < N_OUP; g++) begin : g_usage_chk
      assert property (@(posedge clk_i) disable iff (!rst_ni) usage[g] <= DEPTH_C);
   end

endmodule

// File: tb/tb_stream_demux_fifo.sv
// Bench for stream_demux_fifo (N_OUP=3, DEPTH=3): directed steps plus a random
// phase, all checked against a queue-per-output reference model.
module tb_stream_demux_fifo;

   localparam int unsigned N  = 3;
   localparam int unsigned D  = 3;
   localparam int unsigned DW = 16;
   localparam int unsigned SW = 2;
   localparam int unsigned CW = 2;

   logic            clk_i = 1'b0;
   logic            rst_ni;
   logic            flush_i;
   logic            inp_valid_i;
   logic            inp_ready_o;
   logic [DW-1:0]   inp_data_i;
   logic [SW-1:0]   oup_sel_i;
   logic [N-1:0]    oup_valid_o;
   logic [N-1:0]    oup_ready_i;
   logic [N*DW-1:0] oup_data_o;
   logic [N*CW-1:0] usage_o;
   logic            err_o;

   stream_demux_fifo #(.N_OUP(N), .DATA_WIDTH(DW), .DEPTH(D)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
      .inp_valid_i(inp_valid_i), .inp_ready_o(inp_ready_o),
      .inp_data_i(inp_data_i), .oup_sel_i(oup_sel_i),
      .oup_valid_o(oup_valid_o), .oup_ready_i(oup_ready_i),
      .oup_data_o(oup_data_o), .usage_o(usage_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   logic [DW-1:0] q [N][$];
   logic          m_err;
   logic          last_acc;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < N; i++) q[i].delete();
      m_err = 1'b0;
   endtask

   // Inputs are driven just after a falling edge; tick checks, then models the next rising edge.
   task automatic tick();
      logic exp_rdy;
      logic acc;
      #1;
      exp_rdy = !flush_i && ((oup_sel_i >= N) || (q[oup_sel_i].size() < D));
      chk("inp_ready", inp_ready_o, exp_rdy);
      for (int i = 0; i < N; i++) begin
         chk($sformatf("valid%0d", i), oup_valid_o[i], q[i].size() != 0);
         chk($sformatf("usage%0d", i), usage_o[i*CW +: CW], q[i].size());
         if (q[i].size() != 0) chk($sformatf("data%0d", i), oup_data_o[i*DW +: DW], q[i][0]);
      end
      chk("err", err_o, m_err);
      acc = inp_valid_i && exp_rdy;
      @(posedge clk_i);
      if (flush_i) model_clear();
      else begin
         for (int i = 0; i < N; i++)
            if (oup_ready_i[i] && q[i].size() != 0) void'(q[i].pop_front());
         if (acc) begin
            if (oup_sel_i >= N) m_err = 1'b1;
            else q[oup_sel_i].push_back(inp_data_i);
         end
      end
      last_acc = acc;
      @(negedge clk_i);
   endtask

   task automatic drive(input logic v, input logic [SW-1:0] s, input logic [DW-1:0] d,
                        input logic [N-1:0] r);
      inp_valid_i = v;
      oup_sel_i   = s;
      inp_data_i  = d;
      oup_ready_i = r;
   endtask

   initial begin
      rst_ni = 1'b0;
      flush_i = 1'b0;
      drive(1'b0, '0, '0, '0);
      model_clear();
      last_acc = 1'b0;
      #1;
      chk("rst_ready", inp_ready_o, 1'b0);
      chk("rst_valid", oup_valid_o, 3'b000);
      chk("rst_usage", usage_o, '0);
      chk("rst_err", err_o, 1'b0);
      @(negedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // idle: ready for every selector, including out-of-range
      for (int s = 0; s < 4; s++) begin
         drive(1'b0, SW'(s), '0, '0);
         tick();
      end

      // routing and one-cycle latency
      drive(1'b1, 2'd2, 16'h00A5, 3'b000);
      tick();
      drive(1'b0, 2'd0, 16'h0000, 3'b100);
      #1;
      chk("route_valid", oup_valid_o, 3'b100);
      chk("route_data", oup_data_o[2*DW +: DW], 16'h00A5);
      tick();
      drive(1'b0, 2'd0, 16'h0000, 3'b000);
      #1;
      chk("route_popped", usage_o[2*CW +: CW], 2'd0);
      tick();

      // fill output 1, keep output 0 flowing, then block the fourth beat
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 2'd1, 16'h1100 + 16'(k), 3'b000);
         tick();
      end
      drive(1'b1, 2'd0, 16'h0BEE, 3'b000);
      tick();
      drive(1'b1, 2'd1, 16'h1103, 3'b000);
      #1;
      chk("full_block", inp_ready_o, 1'b0);
      tick();
      tick();
      drive(1'b1, 2'd1, 16'h1103, 3'b010);
      tick();
      drive(1'b1, 2'd1, 16'h1103, 3'b000);
      #1;
      chk("full_release", inp_ready_o, 1'b1);
      tick();
      drive(1'b0, 2'd0, 16'h0000, 3'b111);
      for (int k = 0; k < 5; k++) tick();

      // steady push+pop at usage 1 on output 2, wraps pointers several times
      drive(1'b1, 2'd2, 16'h2200, 3'b000);
      tick();
      for (int k = 1; k <= 10; k++) begin
         drive(1'b1, 2'd2, 16'h2200 + 16'(k), 3'b100);
         tick();
         chk("pp_usage", usage_o[2*CW +: CW], 2'd1);
      end
      drive(1'b0, 2'd0, 16'h0000, 3'b111);
      tick();

      // out-of-range selector, then flush
      drive(1'b1, 2'd0, 16'h0C0C, 3'b000);
      tick();
      drive(1'b1, 2'd3, 16'hDEAD, 3'b000);
      tick();
      drive(1'b0, 2'd0, 16'h0000, 3'b000);
      #1;
      chk("oor_err", err_o, 1'b1);
      chk("oor_valid", oup_valid_o, 3'b001);
      tick();
      flush_i = 1'b1;
      oup_ready_i = 3'b111;
      tick();
      flush_i = 1'b0;
      oup_ready_i = 3'b000;
      #1;
      chk("flush_err", err_o, 1'b0);
      chk("flush_usage", usage_o, '0);
      tick();

      // random traffic honouring input stability while stalled
      for (int c = 0; c < 400; c++) begin
         if (!(inp_valid_i && !last_acc)) begin
            inp_valid_i = 1'($urandom_range(0, 1));
            oup_sel_i   = SW'($urandom_range(0, 3));
            inp_data_i  = DW'($urandom);
         end
         oup_ready_i = N'($urandom);
         flush_i     = ($urandom_range(0, 31) == 0);
         tick();
      end
      flush_i = 1'b0;

      // reset mid-cycle with two outputs holding two beats each
      drive(1'b0, 2'd0, 16'h0000, 3'b111);
      tick();
      drive(1'b0, 2'd0, 16'h0000, 3'b000);
      tick();
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, SW'(k / 2), 16'h5500 + 16'(k), 3'b000);
         tick();
      end
      drive(1'b0, 2'd0, 16'h0000, 3'b000);
      #1;
      chk("pre_rst_valid", oup_valid_o, 3'b011);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("mid_rst_valid", oup_valid_o, 3'b000);
      chk("mid_rst_usage", usage_o, '0);
      chk("mid_rst_ready", inp_ready_o, 1'b0);
      model_clear();
      @(negedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
      tick();
      drive(1'b1, 2'd1, 16'h7777, 3'b000);
      tick();
      drive(1'b0, 2'd0, 16'h0000, 3'b010);
      #1;
      chk("post_rst_data", oup_data_o[1*DW +: DW], 16'h7777);
      tick();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
